// File: rtl/sram_sp_arbiter.sv
// Single-port SRAM arbiter: one write and one read requester share a CEB/WEB/A/D/Q macro,
// with write priority, a read starvation guard and a 2-entry read response FIFO.
// Optional power-on zero sweep of the macro is enabled by defining SRAM_ARB_INIT_EN.
module sram_sp_arbiter #(
  parameter int DATA_WIDTH   = 80,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_width
    $error("sram_sp_arbiter: ADDR_WIDTH must equal clog2(DEPTH)");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("sram_sp_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                  state;
  logic                    init_done_q;
  logic [ADDR_WIDTH-1:0]   init_addr;
  logic                    sweep;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    fifo_rd_ptr;
  logic                    fifo_wr_ptr;
  logic [1:0]              fifo_count;
  logic                    in_flight;
  logic [3:0]              starve_cnt;
  logic                    starved;
  logic                    push;
  logic                    pop;
  logic [2:0]              pending;
  logic                    eligible;
  logic                    wr_grant;
  logic                    rd_grant;

`ifdef SRAM_ARB_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_INIT;
      init_done_q <= 1'b0;
      init_addr   <= '0;
    end else if (state == ST_INIT) begin
      init_addr <= init_addr + ADDR_WIDTH'(1);
      if (init_addr == LAST_ADDR) begin
        state       <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  // Gated by RST_N so the macro is released the instant reset asserts.
  assign sweep = (state == ST_INIT) && RST_N;
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_INIT;
      init_done_q <= 1'b0;
    end else if (state == ST_INIT) begin
      state       <= ST_RUN;
      init_done_q <= 1'b1;
    end
  end

  assign init_addr = '0;
  assign sweep     = 1'b0;
`endif

  assign init_done = init_done_q;

  // Eligibility counts the slot freed by this cycle's pop, so reads stream at one per cycle
  // while the FIFO drains, yet FIFO entries plus the in-flight read never exceed two.
  assign push     = in_flight;
  assign pop      = (fifo_count != 2'd0) && rsp_ready;
  assign pending  = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight};
  assign eligible = pending < 3'd2;
  assign starved  = starve_cnt == LIMIT;

  assign rd_ready = init_done_q && eligible && (!wr_valid || starved);
  assign wr_ready = init_done_q && !(rd_valid && rd_ready);
  assign rd_grant = rd_valid && rd_ready;
  assign wr_grant = wr_valid && wr_ready;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (sweep) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = init_addr;
    end else if (wr_grant) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = wr_addr;
      sram_d   = wr_data;
    end else if (rd_grant) begin
      sram_ceb = 1'b0;
      sram_a   = rd_addr;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt <= '0;
    end else if (!rd_valid || rd_grant) begin
      starve_cnt <= '0;
    end else if (eligible && wr_grant && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // NOTE: the two FIFO words are reset (cheap at this size) so rsp_data reads 0 out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      in_flight   <= 1'b0;
    end else begin
      in_flight <= rd_grant;
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= sram_q;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
    end
  end

  assign rsp_valid = fifo_count != 2'd0;
  assign rsp_data  = fifo_mem[fifo_rd_ptr];

endmodule
